fixconv_rr_arbiter: RTL
=======================

// Module: fixconv_rr_arbiter
// PURPOSE
//  Shares one fixed-to-single converter among NUM_REQ requesters using round-robin arbitration.
//  Each requester hands over an unsigned fixed-point operand through a valid/ready handshake.
//  The block captures the operand, converts it, and returns an IEEE-754 single tagged with the requester ID.
//  It sits between the fast-inverse-sqrt peripheral's operand sources and its float datapath.
// PARAMETERS
//  NUM_REQ      4   number of requesters, 2..8
//  INT_WIDTH   12   integer bits of the operand
//  FRACT_WIDTH  4   fractional bits of the operand; INT_WIDTH+FRACT_WIDTH (=FW) must be <= 24
//  ID_WIDTH     $clog2(NUM_REQ)   derived localparam, not overridable
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  req_valid  in   NUM_REQ      per-requester operand valid
//  req_data   in   NUM_REQ*FW   operand i occupies bits [i*FW +: FW]
//  req_ready  out  NUM_REQ      one-hot grant/accept; at most one bit set
//  res_valid  out  1            result valid
//  res_ready  in   1            downstream accepts result
//  res_data   out  32           IEEE-754 single result
//  res_id     out  ID_WIDTH     index of the requester that produced res_data
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority; res_valid=0;
//   res_data=0; res_id=0; req_ready=0.
//  States:
//   IDLE: grant = first valid requester searching from rr_ptr+1 (mod NUM_REQ).
//   CONV: one cycle; convert op_q, register res_data/res_id, set res_valid=1, go to HOLD.
//   HOLD: res_valid=1 with res_data/res_id stable until res_ready=1.
//  Transfers:
//   - Accept = req_valid[g] & req_ready[g].
//   - req_ready is combinational: asserted in IDLE, and in HOLD when res_ready=1.
//   - Never asserted in CONV. Never asserted for a requester whose req_valid is 0.
//   - On accept: op_q <= operand g, id_q <= g, rr_ptr <= g, next state CONV.
//   - HOLD with res_ready=1 and an accept in the same cycle: next state CONV; res_valid drops for exactly the CONV cycle.
//   - HOLD with res_ready=1 and no accept: next state IDLE, res_valid <= 0.
//  Latency: accept at edge N -> res_valid=1 after edge N+1. Peak throughput 1 result per 2 cycles.
//  Requester rules: must hold req_valid/req_data until accepted. A withdrawn request is simply not granted.
//  Conversion (unsigned, truncating):
//   - Operand 0 -> 32'h0000_0000.
//   - Otherwise lz = leading zeros of FW-bit op; exp = 127 + (INT_WIDTH-1-lz).
//   - Mantissa = bits below the leading 1, left-aligned into 23 bits, zero-filled, no rounding; sign=0.
//  Fairness: a continuously-valid requester is granted within NUM_REQ grants.
//  Reset mid-operation: asynchronous clear of state/outputs; any captured operand is dropped, no result emitted.
// CONFIGURATION
//  `FIXCONV_ARB_STATS_EN defined:
//   - Adds output grant_cnt [NUM_REQ*16-1:0], one 16-bit counter per requester.
//   - Counter i increments on each accept from requester i and saturates at 16'hFFFF.
//   - Reset to 0.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package fixconv_pkg:
//   - state enum {IDLE, CONV, HOLD}
//   - FLOAT_ZERO = 32'h0, FLOAT_BIAS = 8'd127
//   - fix_width function returning INT_WIDTH+FRACT_WIDTH
//  Sub-module fixconv_rr_pick: combinational round-robin picker.
//   - In: valid vector, rr_ptr. Out: one-hot grant, grant index, any_valid.
//  Conversion: the team's combinational fixed-to-single converter, instantiated once on op_q.
// TESTING (INT_WIDTH=12, FRACT_WIDTH=4, NUM_REQ=4)
//  1. Req0 sends 16'h0010, res_ready=1 -> res_data=32'h3F80_0000, res_id=0, 1 cycle after accept.
//  2. Operands 16'h0018, 16'h0001, 16'hFFFF, 16'h0000
//     -> 32'h3FC0_0000, 32'h3D80_0000, 32'h457F_FF00, 32'h0000_0000.
//  3. All four requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,...; one result every 2 cycles.
//  4. res_ready=0 for 5 cycles in HOLD -> res_data/res_id stable, req_ready all 0; release -> next grant that cycle.
//  5. rst_n pulsed low during CONV -> res_valid=0 immediately, no result emitted; next grant goes to requester 0.
//  6. With `FIXCONV_ARB_STATS_EN: 70000 accepts from req2 -> grant_cnt[2]=16'hFFFF, others unchanged.

Source files
------------

// File: rtl/fixconv_pkg.sv
// Shared types and constants for the round-robin fixed-to-single converter.
package fixconv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [31:0] FLOAT_ZERO   = 32'h0000_0000;
    localparam logic [7:0]  FLOAT_BIAS   = 8'd127;
    localparam int unsigned FLOAT_MANT_W = 23;

    typedef struct packed {
        logic                    sign;
        logic [7:0]              exp;
        logic [FLOAT_MANT_W-1:0] mant;
    } float_t;

    function automatic int unsigned fix_width(input int unsigned int_width,
                                              input int unsigned fract_width);
        return int_width + fract_width;
    endfunction

endpackage

// File: rtl/fixconv_rr_pick.sv
// Combinational round-robin picker: first valid requester after i_rr_ptr, wrapping.
module fixconv_rr_pick #(
    parameter  int unsigned NUM_REQ  = 4,
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_valid,
    input  logic [ID_WIDTH-1:0] i_rr_ptr,
    output logic [NUM_REQ-1:0]  o_grant_c,
    output logic [ID_WIDTH-1:0] o_idx_c,
    output logic                o_any_c
);

    logic [ID_WIDTH-1:0] w_cand;

    // Walk from farthest to nearest so the nearest valid candidate wins.
    always_comb begin
        o_idx_c = '0;
        w_cand  = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            w_cand = ID_WIDTH'((int'(i_rr_ptr) + k) % int'(NUM_REQ));
            if (i_valid[w_cand]) begin
                o_idx_c = w_cand;
            end
        end
        o_any_c   = |i_valid;
        o_grant_c = o_any_c ? (NUM_REQ'(1) << o_idx_c) : '0;
    end

endmodule

// File: rtl/fixconv_to_float.sv
// Combinational unsigned fixed-point to IEEE-754 single converter (truncating).
module fixconv_to_float
    import fixconv_pkg::*;
#(
    parameter  int unsigned INT_WIDTH   = 12,
    parameter  int unsigned FRACT_WIDTH = 4,
    localparam int unsigned FW          = fix_width(INT_WIDTH, FRACT_WIDTH),
    localparam int unsigned LZW         = $clog2(FW + 1)
) (
    input  logic [FW-1:0] i_op,
    output logic [31:0]   o_float_c
);

    logic [LZW-1:0] w_lz;
    logic [FW-1:0]  w_norm;
    logic [FW+22:0] w_ext;
    float_t         w_f;

    always_comb begin
        w_lz = LZW'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (i_op[i]) begin
                w_lz = LZW'(int'(FW) - 1 - i);
            end
        end
        // Leading one lands on the MSB; the bits below it become the mantissa.
        w_norm    = i_op << w_lz;
        w_ext     = {w_norm[FW-2:0], 24'd0};
        w_f.sign  = 1'b0;
        w_f.exp   = 8'(int'(FLOAT_BIAS) + int'(INT_WIDTH) - 1 - int'(w_lz));
        w_f.mant  = w_ext[FW+22 -: FLOAT_MANT_W];
        o_float_c = (i_op == '0) ? FLOAT_ZERO : w_f;
    end

endmodule

// File: rtl/fixconv_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-to-single converter among NUM_REQ requesters.
// Optional per-requester accept counters enabled by `FIXCONV_ARB_STATS_EN.
module fixconv_rr_arbiter
    import fixconv_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned INT_WIDTH   = 12,
    parameter  int unsigned FRACT_WIDTH = 4,
    localparam int unsigned FW          = fix_width(INT_WIDTH, FRACT_WIDTH),
    localparam int unsigned ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*FW-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic [ID_WIDTH-1:0]    res_id,
`ifdef FIXCONV_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]  grant_cnt,
`endif
    output logic                   busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_WIDTH-1:0] r_rr_ptr;
    logic [ID_WIDTH-1:0] r_id;
    logic [FW-1:0]       r_op;
    logic                r_res_valid;
    logic [31:0]         r_res_data;
    logic [ID_WIDTH-1:0] r_res_id;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_WIDTH-1:0] w_gnt_idx;
    logic                w_any;
    logic                w_rdy_en;
    logic [NUM_REQ-1:0]  w_accept_vec;
    logic                w_accept;
    logic [FW-1:0]       w_sel_op;
    logic [31:0]         w_float;

    fixconv_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_valid   (req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant_c (w_gnt),
        .o_idx_c   (w_gnt_idx),
        .o_any_c   (w_any)
    );

    fixconv_to_float #(
        .INT_WIDTH   (INT_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_conv (
        .i_op      (r_op),
        .o_float_c (w_float)
    );

    // A new operand may enter only when the result slot is free or draining this cycle.
    assign w_rdy_en     = (r_state == IDLE) || ((r_state == HOLD) && res_ready);
    assign req_ready    = (w_rdy_en && w_any) ? w_gnt : '0;
    assign w_accept_vec = req_valid & req_ready;
    assign w_accept     = |w_accept_vec;

    always_comb begin
        w_sel_op = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_gnt[i]) begin
                w_sel_op = req_data[i*FW +: FW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    w_state_nxt = w_accept ? CONV : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and round-robin pointer advance on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_id     <= '0;
            r_rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_op     <= w_sel_op;
            r_id     <= w_gnt_idx;
            r_rr_ptr <= w_gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= FLOAT_ZERO;
            r_res_id    <= '0;
        end else if (r_state == CONV) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_float;
            r_res_id    <= r_id;
        end else if ((r_state == HOLD) && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = (r_state != IDLE);

`ifdef FIXCONV_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    // Saturating per-requester accept counters.
    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_stats
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_grant_cnt[g] <= '0;
            end else if (w_accept_vec[g] && (r_grant_cnt[g] != 16'hFFFF)) begin
                r_grant_cnt[g] <= r_grant_cnt[g] + 16'd1;
            end
        end
        assign grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
`endif

endmodule
